mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 NREQ, 4, number of requesters sharing one serial 16x16 multiplier; range 2..8.
REQ-002 IDW, $clog2(NREQ), requester-id width.
REQ-003 TIMEOUT, 32, max cycles spent in WAIT before the operation is aborted; range 4..255.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_a  in  NREQ*16  packed multiplicand; requester i uses bits [16i+15:16i].
REQ-008 req_b  in  NREQ*16  packed multiplier, same packing as req_a.
REQ-009 req_ready  out  NREQ  per-requester accept strobe, at most one bit set.
REQ-010 mul_in1  out  16  operand A to the multiplier.
REQ-011 mul_in2  out  16  operand B to the multiplier.
REQ-012 mul_start  out  1  single-cycle start pulse to the multiplier.
REQ-013 mul_out  in  32  multiplier product, valid in the cycle mul_done=1.
REQ-014 mul_done  in  1  multiplier completion pulse.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_id  out  IDW  id of the requester owning the response.
REQ-017 rsp_data  out  32  product, or 0 on timeout.
REQ-018 rsp_err  out  1  1 = operation timed out.
REQ-019 rsp_ready  in  1  response consumer accept.
REQ-020 busy  out  1  1 in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transition per cycle at most.
REQ-022 IDLE: if any req_valid bit is set, the winner SHALL be the first set bit searching upward from ptr, wrapping from NREQ-1 to 0.
REQ-023 IDLE with a winner: req_ready[winner]=1 combinationally that cycle; operands and id registered; next state ISSUE.
REQ-024 IDLE with no req_valid: req_ready=0, state held.
REQ-025 req_ready SHALL be 0 in all states except IDLE.
REQ-026 ISSUE: mul_start=1 for exactly one cycle; wait timer cleared; next state WAIT.
REQ-027 mul_in1/mul_in2 SHALL hold the registered operands, constant from ISSUE through the end of WAIT.
REQ-028 WAIT with mul_done=1: rsp_data<=mul_out, rsp_err<=0, next state RESP.
REQ-029 WAIT without mul_done: timer increments each cycle.
REQ-030 WAIT timeout: when timer reaches TIMEOUT-1 without mul_done, rsp_data<=0, rsp_err<=1, next state RESP.
REQ-031 mul_done and timeout in the same cycle: mul_done wins, so rsp_err=0.
REQ-032 mul_done outside WAIT SHALL be ignored.
REQ-033 RESP: rsp_valid=1; rsp_id/rsp_data/rsp_err stable until a cycle with rsp_ready=1.
REQ-034 RESP exit: on rsp_ready=1 the next state is IDLE and ptr<=(rsp_id+1) mod NREQ.
REQ-035 No new request SHALL be accepted while a response is pending (single outstanding operation).
REQ-036 Latency: accept cycle to mul_start is exactly 1 cycle; mul_done cycle to rsp_valid is exactly 1 cycle.

Reset
REQ-037 On a clk edge with reset=0, the block SHALL set: state IDLE, ptr 0, timer 0.
REQ-038 Reset values of outputs: rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, mul_start=0, mul_in1/mul_in2=0, busy=0.
REQ-039 Reset asserted in any state SHALL abort the operation with no response; any later mul_done is ignored.
REQ-040 During reset, req_ready SHALL be 0.

Verification
REQ-041 Single request: req 2, a=3, b=5; model returns done after 19 cycles -> exactly one mul_start pulse, then rsp_valid with id=2, data=15, err=0.
REQ-042 Round-robin: all four req_valid held continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no requester starved.
REQ-043 Backpressure: rsp_ready=0 for 10 cycles -> rsp fields stable, req_ready stays 0; release -> IDLE one cycle later.
REQ-044 Timeout: model never asserts done, TIMEOUT=32 -> rsp_err=1, data=0, rsp_valid 33 cycles after mul_start.
REQ-045 Boundary: a=b=16'hFFFF -> data=32'hFFFE0001; done on the final timeout cycle -> err=0.
REQ-046 Reset mid-WAIT, then a late mul_done -> no rsp_valid, ptr=0, next grant goes to lowest valid requester.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin front end that lets NREQ requesters share one serial 16x16 multiplier.
// One operation is outstanding at a time; a stalled multiplier is cut off by a wait timeout.
module mult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = $clog2(NREQ),
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_in1,
  output logic [15:0]          mul_in2,
  output logic                 mul_start,
  input  logic [31:0]          mul_out,
  input  logic                 mul_done,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int unsigned OPW = 16;
  localparam int unsigned TW  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [TW-1:0]   timer;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [OPW-1:0]  sel_a;
  logic [OPW-1:0]  sel_b;

  // First requesting index at or above ptr, wrapping past NREQ-1.
  always_comb begin : arbitrate
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!win_found && req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin : operand_mux
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  always_comb begin : grant
    req_ready = '0;
    if (reset && (state == S_IDLE) && win_found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin : fsm
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      timer     <= '0;
      mul_in1   <= '0;
      mul_in2   <= '0;
      mul_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            mul_in1   <= sel_a;
            mul_in2   <= sel_b;
            rsp_id    <= win_id;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the last allowed cycle still beats the timeout.
          if (mul_done) begin
            rsp_data  <= mul_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
